// File: rtl/bf16_pkg.sv
// Shared BF16 field widths, constants, operand layout and divider FSM states.
package bf16_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [15:0] QNAN = 16'h7FC0;
  localparam logic [15:0] PINF = 16'h7F80;

  typedef struct packed {
    logic                  sign;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StIter,
    StRound,
    StDone
  } state_e;

endpackage

// File: rtl/bf16_div_lane.sv
// One BF16 divider lane: operand capture, special-case decode, one restoring
// quotient bit per iteration cycle, then rounding and packing.
module bf16_div_lane
  import bf16_pkg::*;
#(
  parameter int unsigned ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        pre,
  input  logic        iter,
  input  logic        round,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c,
  output logic        dz,
  output logic        nv
);

  bf16_t              a_q, b_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [8:0]         rem_q;
  logic [7:0]         div_q;
  logic [7:0]         quo_q;
  logic               spec_q, spec_dz_q, spec_nv_q;
  logic [15:0]        spec_val_q;

  logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign;
  logic [7:0]         ma, mb;
  logic               lt;
  logic [8:0]         rem_pre;
  logic signed [9:0]  e_pre;
  logic               sp, sp_dz, sp_nv;
  logic [15:0]        sp_val;

  logic               ge;
  logic [7:0]         rem_sub;
  logic               inc;
  logic [7:0]         mant;
  logic signed [9:0]  e_rnd;
  logic [15:0]        res;

  // Unpack, special-case decode and pre-normalisation (consumed in PRE)
  always_comb begin
    a_zero  = (a_q.exp == 8'd0);
    b_zero  = (b_q.exp == 8'd0);
    a_inf   = (a_q.exp == 8'hFF) && (a_q.man == 7'd0);
    b_inf   = (b_q.exp == 8'hFF) && (b_q.man == 7'd0);
    a_nan   = (a_q.exp == 8'hFF) && (a_q.man != 7'd0);
    b_nan   = (b_q.exp == 8'hFF) && (b_q.man != 7'd0);
    sign    = a_q.sign ^ b_q.sign;
    ma      = {1'b1, a_q.man};
    mb      = {1'b1, b_q.man};
    lt      = (ma < mb);
    rem_pre = lt ? {ma, 1'b0} : {1'b0, ma};
    e_pre   = $signed({2'b00, a_q.exp} - {2'b00, b_q.exp} + 10'(BF16_BIAS) - {9'd0, lt});

    sp     = 1'b1;
    sp_dz  = 1'b0;
    sp_nv  = 1'b0;
    sp_val = QNAN;
    if (a_nan || b_nan) begin
      sp_nv = 1'b1;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_nv = 1'b1;
    end else if (a_inf) begin
      sp_val = PINF | {sign, 15'd0};
    end else if (b_zero) begin
      sp_val = PINF | {sign, 15'd0};
      sp_dz  = 1'b1;
    end else if (a_zero || b_inf) begin
      sp_val = {sign, 15'd0};
    end else begin
      sp = 1'b0;
    end
  end

  // Restoring step: remainder stays below twice the divisor, so 9 bits suffice
  always_comb begin
    ge      = (rem_q >= {1'b0, div_q});
    rem_sub = ge ? 8'(rem_q - {1'b0, div_q}) : rem_q[7:0];
  end

  // quo_q holds the 7 fraction bits plus guard; the leading 1 has shifted out
  always_comb begin
    inc   = (ROUND_MODE == 0) && quo_q[0] && ((rem_q != 9'd0) || quo_q[1]);
    mant  = {1'b0, quo_q[7:1]} + {7'd0, inc};
    e_rnd = exp_q + $signed({9'd0, mant[7]});
    if (spec_q) begin
      res = spec_val_q;
    end else if (e_rnd >= 10'sd255) begin
      res = PINF | {sign_q, 15'd0};
    end else if (e_rnd <= 10'sd0) begin
      res = {sign_q, 15'd0};
    end else begin
      res = {sign_q, e_rnd[7:0], mant[6:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      spec_q     <= 1'b0;
      spec_dz_q  <= 1'b0;
      spec_nv_q  <= 1'b0;
      spec_val_q <= '0;
      c          <= '0;
      dz         <= 1'b0;
      nv         <= 1'b0;
    end else begin
      if (load) begin
        a_q <= a;
        b_q <= b;
        dz  <= 1'b0;
        nv  <= 1'b0;
      end
      if (pre) begin
        sign_q     <= sign;
        exp_q      <= e_pre;
        rem_q      <= rem_pre;
        div_q      <= mb;
        quo_q      <= '0;
        spec_q     <= sp;
        spec_dz_q  <= sp_dz;
        spec_nv_q  <= sp_nv;
        spec_val_q <= sp_val;
      end
      if (iter) begin
        rem_q <= {rem_sub, 1'b0};
        quo_q <= {quo_q[6:0], ge};
      end
      if (round) begin
        c  <= res;
        dz <= spec_q & spec_dz_q;
        nv <= spec_q & spec_nv_q;
      end
    end
  end

endmodule

// File: rtl/bf16_div_vec_seq.sv
// N-lane sequential BF16 divider: one shared FSM and iteration counter
// sequence all lanes through PRE, 9 ITER cycles, ROUND and DONE.
module bf16_div_vec_seq
  import bf16_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned ROUND_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*N-1:0] a,
  input  logic [16*N-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16*N-1:0] c,
  output logic [N-1:0]    dz_flag,
  output logic [N-1:0]    nv_flag,
  output logic            busy
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept, pre_en, iter_en, round_en;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign accept    = in_valid & in_ready;
  assign pre_en    = (state_q == StPre);
  assign iter_en   = (state_q == StIter);
  assign round_en  = (state_q == StRound);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StPre;
      StPre: begin
        cnt_d   = 4'd0;
        state_d = StIter;
      end
      StIter: begin
        if (cnt_q == 4'd8) state_d = StRound;
        else               cnt_d   = cnt_q + 4'd1;
      end
      StRound: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    bf16_div_lane #(
      .ROUND_MODE(ROUND_MODE)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .pre  (pre_en),
      .iter (iter_en),
      .round(round_en),
      .a    (a[16*i +: 16]),
      .b    (b[16*i +: 16]),
      .c    (c[16*i +: 16]),
      .dz   (dz_flag[i]),
      .nv   (nv_flag[i])
    );
  end

endmodule

// File: tb/tb_bf16_div_vec_seq.sv
// Bench for bf16_div_vec_seq: directed and random vectors against an exact
// rational-arithmetic BF16 division model, for both rounding modes.
module tb_bf16_div_vec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [63:0] a, b;
  logic        in_ready, out_valid, busy;
  logic [63:0] c;
  logic [3:0]  dz_flag, nv_flag;
  logic        in_ready_t, out_valid_t, busy_t;
  logic [63:0] c_t;
  logic [3:0]  dz_t, nv_t;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf16_div_vec_seq #(.N(4), .ROUND_MODE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .dz_flag(dz_flag),
    .nv_flag(nv_flag), .busy(busy)
  );

  bf16_div_vec_seq #(.N(4), .ROUND_MODE(1)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .a(a), .b(b),
    .out_valid(out_valid_t), .out_ready(out_ready), .c(c_t), .dz_flag(dz_t),
    .nv_flag(nv_t), .busy(busy_t)
  );

  // Exact quotient of the significands, rounded from the true remainder.
  function automatic logic [17:0] ref_lane(input logic [15:0] x, input logic [15:0] y,
                                           input int mode);
    int     ex, ey, fx, fy, e, sh;
    longint num, q, r, m, low, half;
    logic   s, xz, yz, xi, yi, xn, yn;
    s  = x[15] ^ y[15];
    ex = int'(x[14:7]);
    ey = int'(y[14:7]);
    fx = int'(x[6:0]);
    fy = int'(y[6:0]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (fx == 0);
    yi = (ey == 255) && (fy == 0);
    xn = (ex == 255) && (fx != 0);
    yn = (ey == 255) && (fy != 0);
    if (xn || yn) return {2'b10, 16'h7FC0};
    if ((xz && yz) || (xi && yi)) return {2'b10, 16'h7FC0};
    if (xi) return {2'b00, s, 15'h7F80};
    if (yz) return {2'b01, s, 15'h7F80};
    if (xz || yi) return {2'b00, s, 15'h0000};
    num = longint'(128 + fx) << 20;
    q   = num / longint'(128 + fy);
    r   = num % longint'(128 + fy);
    e   = ex - ey + 127;
    sh  = 13;
    if (q < (longint'(1) << 20)) begin
      sh = 12;
      e  = e - 1;
    end
    m    = q >> sh;
    low  = q - (m << sh);
    half = longint'(1) << (sh - 1);
    if (mode == 0 && (low > half || (low == half && (r != 0 || (m % 2) == 1)))) m = m + 1;
    if (m == 256) begin
      m = 128;
      e = e + 1;
    end
    if (e >= 255) return {2'b00, s, 15'h7F80};
    if (e <= 0) return {2'b00, s, 15'h0000};
    return {2'b00, s, 8'(e), 7'(m)};
  endfunction

  function automatic logic [71:0] ref_vec(input logic [63:0] av, input logic [63:0] bv,
                                          input int mode);
    logic [63:0] cc;
    logic [3:0]  dd, nn;
    logic [17:0] t;
    for (int i = 0; i < 4; i++) begin
      t = ref_lane(av[16*i +: 16], bv[16*i +: 16], mode);
      cc[16*i +: 16] = t[15:0];
      dd[i] = t[16];
      nn[i] = t[17];
    end
    return {nn, dd, cc};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    int k;
    k = int'($urandom_range(0, 19));
    v[15]   = 1'($urandom_range(0, 1));
    v[6:0]  = 7'($urandom_range(0, 127));
    if (k == 0)      v[14:7] = 8'd0;
    else if (k == 1) begin v[14:7] = 8'hFF; v[6:0] = 7'd0; end
    else if (k == 2) begin v[14:7] = 8'hFF; v[6:0] = 7'($urandom_range(1, 127)); end
    else if (k < 10) v[14:7] = 8'($urandom_range(1, 254));
    else             v[14:7] = 8'($urandom_range(110, 144));
    return v;
  endfunction

  // Issue one operand set, wait (bounded) for the result, then consume it.
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv, output int lat,
                       output logic ok, output logic [63:0] rc, output logic [63:0] rc_t,
                       output logic [3:0] rdz, output logic [3:0] rnv);
    int guard;
    guard = 0;
    lat   = 0;
    ok    = 1'b0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    rc   = c;
    rc_t = c_t;
    rdz  = dz_flag;
    rnv  = nv_flag;
    if (ok) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got %b want 0", out_valid); n_err++;
    end
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_ready_busy got %b%b want 10", in_ready, busy); n_err++;
    end
    n_vec++;
    if (c !== 64'd0 || dz_flag !== 4'd0 || nv_flag !== 4'd0) begin
      $display("FAIL reset_outputs got c=%h dz=%b nv=%b want 0", c, dz_flag, nv_flag); n_err++;
    end
  endtask

  task automatic test_basic();
    int lat; logic ok; logic [63:0] rc, rc_t; logic [3:0] rdz, rnv;
    do_op({4{16'hC170}}, {4{16'h4120}}, lat, ok, rc, rc_t, rdz, rnv);
    n_vec++;
    if (!ok || lat != 11) begin
      $display("FAIL basic_latency got %0d (ok=%b) want 11", lat, ok); n_err++;
    end
    n_vec++;
    if (rc !== {4{16'hBFC0}}) begin
      $display("FAIL basic_c got %h want %h", rc, {4{16'hBFC0}}); n_err++;
    end
    n_vec++;
    if (rdz !== 4'd0 || rnv !== 4'd0) begin
      $display("FAIL basic_flags got dz=%b nv=%b want 0000", rdz, rnv); n_err++;
    end
  endtask

  task automatic test_round();
    int lat; logic ok; logic [63:0] rc, rc_t; logic [3:0] rdz, rnv;
    do_op({4{16'h4080}}, {4{16'h4040}}, lat, ok, rc, rc_t, rdz, rnv);
    n_vec++;
    if (rc !== {4{16'h3FAB}}) begin
      $display("FAIL round_rne got %h want %h", rc, {4{16'h3FAB}}); n_err++;
    end
    n_vec++;
    if (rc_t !== {4{16'h3FAA}}) begin
      $display("FAIL round_trunc got %h want %h", rc_t, {4{16'h3FAA}}); n_err++;
    end
  endtask

  task automatic test_specials();
    int lat; logic ok; logic [63:0] rc, rc_t; logic [3:0] rdz, rnv;
    do_op(64'h4000_7F80_0000_3F80, 64'h7F80_4000_0000_0000, lat, ok, rc, rc_t, rdz, rnv);
    n_vec++;
    if (rc !== 64'h0000_7F80_7FC0_7F80) begin
      $display("FAIL specials_c got %h want %h", rc, 64'h0000_7F80_7FC0_7F80); n_err++;
    end
    n_vec++;
    if (rdz !== 4'b0001 || rnv !== 4'b0010) begin
      $display("FAIL specials_flags got dz=%b nv=%b want dz=0001 nv=0010", rdz, rnv); n_err++;
    end
  endtask

  task automatic test_overflow();
    int lat; logic ok; logic [63:0] rc, rc_t; logic [3:0] rdz, rnv;
    do_op(64'h3F80_8000_0080_7F00, 64'h3F80_3F80_7F00_0080, lat, ok, rc, rc_t, rdz, rnv);
    n_vec++;
    if (rc !== 64'h3F80_8000_0000_7F80) begin
      $display("FAIL ovf_unf_c got %h want %h", rc, 64'h3F80_8000_0000_7F80); n_err++;
    end
    n_vec++;
    if (rc_t !== 64'h3F80_8000_0000_7F80 || rdz !== 4'd0 || rnv !== 4'd0) begin
      $display("FAIL ovf_unf_trunc got %h dz=%b nv=%b want %h 0000 0000",
               rc_t, rdz, rnv, 64'h3F80_8000_0000_7F80); n_err++;
    end
  endtask

  task automatic test_random();
    int lat; logic ok; logic [63:0] rc, rc_t, av, bv; logic [3:0] rdz, rnv;
    logic [71:0] exp0, exp1;
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 4; i++) begin
        av[16*i +: 16] = rand_op();
        bv[16*i +: 16] = rand_op();
      end
      exp0 = ref_vec(av, bv, 0);
      exp1 = ref_vec(av, bv, 1);
      do_op(av, bv, lat, ok, rc, rc_t, rdz, rnv);
      n_vec++;
      if (!ok || {rnv, rdz, rc} !== exp0) begin
        $display("FAIL random_rne a=%h b=%h got nv=%b dz=%b c=%h want nv=%b dz=%b c=%h",
                 av, bv, rnv, rdz, rc, exp0[71:68], exp0[67:64], exp0[63:0]); n_err++;
      end
      n_vec++;
      if (rc_t !== exp1[63:0]) begin
        $display("FAIL random_trunc a=%h b=%h got %h want %h", av, bv, rc_t, exp1[63:0]);
        n_err++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic stable; logic [63:0] a1, b1, a2, b2, held; logic [71:0] e1, e2;
    for (int i = 0; i < 4; i++) begin
      a1[16*i +: 16] = rand_op(); b1[16*i +: 16] = rand_op();
      a2[16*i +: 16] = rand_op(); b2[16*i +: 16] = rand_op();
    end
    e1 = ref_vec(a1, b1, 0);
    e2 = ref_vec(a2, b2, 0);
    out_ready = 1'b0;
    a = a1; b = b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    held = c;
    a = a2; b = b2; in_valid = 1'b1;
    stable = out_valid;
    repeat (20) begin
      @(posedge clk); #1;
      if (c !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin
      $display("FAIL bp_hold got c=%h in_ready=%b out_valid=%b want c=%h 0 1",
               c, in_ready, out_valid, held); n_err++;
    end
    n_vec++;
    if (held !== e1[63:0]) begin
      $display("FAIL bp_first_c got %h want %h", held, e1[63:0]); n_err++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      n_err++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL bp_second_accept got busy=%b want 1", busy); n_err++;
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat != 11 || {nv_flag, dz_flag, c} !== e2) begin
      $display("FAIL bp_second_result got lat=%0d c=%h want lat=11 c=%h", lat, c, e2[63:0]);
      n_err++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic ok; logic [63:0] rc, rc_t; logic [3:0] rdz, rnv;
    a = {4{16'h4080}}; b = {4{16'h4040}}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    n_vec++;
    if (busy !== 1'b1 || c === 64'd0) begin
      $display("FAIL midrst_pre got busy=%b c=%h want busy=1 c=prior result", busy, c);
      n_err++;
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || c !== 64'd0 || busy !== 1'b0) begin
      $display("FAIL midrst_state got out_valid=%b in_ready=%b busy=%b c=%h want 0 1 0 0",
               out_valid, in_ready, busy, c); n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op({4{16'hC170}}, {4{16'h4120}}, lat, ok, rc, rc_t, rdz, rnv);
    n_vec++;
    if (!ok || lat != 11 || rc !== {4{16'hBFC0}}) begin
      $display("FAIL midrst_next got lat=%0d c=%h want 11 %h", lat, rc, {4{16'hBFC0}});
      n_err++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_round();
    test_specials();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
